// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types for the CNN accelerator datapath
package cnn_pkg;
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } unloader_state_e;
endpackage

// File: rtl/tile_unloader_if.sv
// tile_unloader_if: tile capture request plus valid/ready word stream
interface tile_unloader_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   logic                   start;
   logic [WIDTH*DEPTH-1:0] par_in;
   logic                   out_ready;
   logic                   out_valid;
   logic [WIDTH-1:0]       out_data;
   logic                   out_last;
   logic                   busy;
   logic                   done;
   modport master (
      output start, par_in, out_ready,
      input  out_valid, out_data, out_last, busy, done
   );
   modport slave (
      input  start, par_in, out_ready,
      output out_valid, out_data, out_last, busy, done
   );
endinterface

// File: rtl/reg_block.sv
// reg_block: enabled register bank with synchronous reset
module reg_block #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   // load d when enabled, clear on reset at the clock edge
   always_ff @(posedge clk)
      if (rst) q <= '0;
      else if (en) q <= d;
endmodule

// File: rtl/tile_unloader.sv
// tile_unloader: captures a tile of DEPTH words and streams it out lowest index first
module tile_unloader
   import cnn_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   tile_unloader_if.slave  bus
);
   localparam int IW = $clog2(DEPTH);
   localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

   unloader_state_e                   state;
   logic [IW-1:0]                     idx;
   logic                              capture;
   logic                              xfer;
   logic [WIDTH*DEPTH-1:0]            shadow;
   logic [DEPTH-1:0][WIDTH-1:0]       words;

   assign capture = bus.start & (state == IDLE);
   assign xfer    = bus.out_valid & bus.out_ready;
   assign words   = shadow;

   reg_block #(.WIDTH(WIDTH * DEPTH)) u_shadow (
      .clk (clk),
      .rst (rst),
      .en  (capture),
      .d   (bus.par_in),
      .q   (shadow)
   );

   // handshake FSM: capture on start, advance idx per transfer, pulse done after the last word
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state         <= IDLE;
         idx           <= '0;
         bus.out_valid <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         if (state == IDLE) begin
            if (bus.start) begin
               state         <= SEND;
               idx           <= '0;
               bus.out_valid <= 1'b1;
               bus.busy      <= 1'b1;
            end
         end else if (xfer) begin
            if (idx == LAST) begin
               state         <= IDLE;
               idx           <= '0;
               bus.out_valid <= 1'b0;
               bus.busy      <= 1'b0;
               bus.done      <= 1'b1;
            end else begin
               idx <= idx + 1'b1;
            end
         end
      end

   // shadow resets only synchronously, so gate the word to keep stale data hidden
   always_comb begin
      bus.out_data = bus.out_valid ? words[idx] : '0;
      bus.out_last = bus.out_valid & (idx == LAST);
   end
endmodule

// File: tb/tb_tile_unloader.sv
// tb_tile_unloader: directed plan plus random traffic against a word-queue reference model
module tb_tile_unloader;
   localparam int WIDTH = 8;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   tile_unloader_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   tile_unloader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;
   logic [WIDTH-1:0] exp_q[$];
   logic exp_done = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs(input string tag);
      logic v;
      v = exp_q.size() > 0;
      check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
      check({tag, ".data"}, 32'(bus.out_data), v ? 32'(exp_q[0]) : 32'h0);
      check({tag, ".last"}, 32'(bus.out_last), 32'(exp_q.size() == 1));
      check({tag, ".busy"}, 32'(bus.busy), 32'(v));
      check({tag, ".done"}, 32'(bus.done), 32'(exp_done));
   endtask

   task automatic cycle(input string tag, input logic st, input logic [31:0] p, input logic rdy);
      logic nd;
      check_outputs(tag);
      bus.start     = st;
      bus.par_in    = p;
      bus.out_ready = rdy;
      nd = 1'b0;
      if (exp_q.size() > 0) begin
         if (rdy) begin
            void'(exp_q.pop_front());
            nd = exp_q.size() == 0;
         end
      end else if (st) begin
         for (int k = 0; k < DEPTH; k++) exp_q.push_back(p[k*WIDTH +: WIDTH]);
      end
      exp_done = nd;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic reset_now(input string tag);
      rst = 1'b1;
      #1;
      exp_q.delete();
      exp_done = 1'b0;
      check_outputs(tag);
      @(negedge clk);
      check_outputs(tag);
      rst = 1'b0;
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.par_in    = '0;
      bus.out_ready = 1'b0;
      #2;
      reset_now("rst_async");
      repeat (3) cycle("idle", 1'b0, 32'h0, 1'b0);

      cycle("basic", 1'b1, 32'h44332211, 1'b1);
      repeat (6) cycle("basic", 1'b0, 32'h0, 1'b1);

      cycle("bp", 1'b1, 32'h44332211, 1'b1);
      cycle("bp", 1'b0, 32'h0, 1'b1);
      repeat (3) cycle("bp_hold", 1'b0, 32'h0, 1'b0);
      repeat (5) cycle("bp", 1'b0, 32'h0, 1'b1);

      cycle("iso", 1'b1, 32'h44332211, 1'b1);
      cycle("iso", 1'b0, 32'hDDCCBBAA, 1'b1);
      cycle("iso", 1'b1, 32'hDDCCBBAA, 1'b1);
      repeat (4) cycle("iso", 1'b0, 32'hDDCCBBAA, 1'b1);

      cycle("b2b", 1'b1, 32'h44332211, 1'b1);
      repeat (4) cycle("b2b", 1'b0, 32'h0, 1'b1);
      cycle("b2b", 1'b1, 32'h0F0E0D0C, 1'b1);
      repeat (6) cycle("b2b", 1'b0, 32'h0, 1'b1);

      cycle("rstmid", 1'b1, 32'h44332211, 1'b1);
      cycle("rstmid", 1'b0, 32'h0, 1'b1);
      cycle("rstmid", 1'b0, 32'h0, 1'b1);
      reset_now("rstmid_rst");
      repeat (2) cycle("rstmid_idle", 1'b0, 32'h0, 1'b1);
      cycle("rstmid_new", 1'b1, 32'h0F0E0D0C, 1'b1);
      repeat (6) cycle("rstmid_new", 1'b0, 32'h0, 1'b1);

      for (int i = 0; i < 400; i++)
         cycle("rand", ($urandom_range(3) == 0), $urandom, ($urandom_range(2) != 0));
      repeat (2) cycle("rand_drain", 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 8 && exp_q.size() > 0; i++) cycle("rand_drain", 1'b0, 32'h0, 1'b1);
      check("rand_empty", 32'(exp_q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
